// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard unit: EX operand forwarding plus the load-use, taken-branch and multi-cycle stall/flush sequencing.
// Forwarding and control outputs are combinational on the registered state; the state, error flag and counters are registered.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int MULTI_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_valid,
  input  logic [4:0]  ex_rs1_addr,
  input  logic [4:0]  ex_rs2_addr,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        ex_valid,
  input  logic        ex_branch_taken,
  input  logic        ex_multi_start,
  input  logic        ex_multi_done,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_reg_write,
  input  logic        mem_valid,
  input  logic [4:0]  wb_rd_addr,
  input  logic        wb_reg_write,
  input  logic        wb_valid,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        bubble_ex,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [1:0]  state,
  output logic        timeout_err,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int WW = (MULTI_TIMEOUT > 2) ? $clog2(MULTI_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    EX_WAIT    = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  state_t          cur_state, nxt_state;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic            to_set;
  logic            s_if, s_id, s_ex, s_bub, s_fif, s_fie;
  logic            mem_fwd_ok, wb_fwd_ok, load_use;

  assign mem_fwd_ok = mem_valid & mem_reg_write & (mem_rd_addr != 5'd0);
  assign wb_fwd_ok  = wb_valid & wb_reg_write & (wb_rd_addr != 5'd0);

  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (mem_fwd_ok && mem_rd_addr == ex_rs1_addr)     forward_a = 2'b10;
    else if (wb_fwd_ok && wb_rd_addr == ex_rs1_addr)  forward_a = 2'b01;
    if (mem_fwd_ok && mem_rd_addr == ex_rs2_addr)     forward_b = 2'b10;
    else if (wb_fwd_ok && wb_rd_addr == ex_rs2_addr)  forward_b = 2'b01;
  end

  assign load_use = ex_valid & ex_mem_read & (ex_rd_addr != 5'd0) & id_valid &
                    ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

  always_comb begin
    nxt_state = cur_state;
    wait_nxt  = wait_cnt;
    to_set    = 1'b0;
    s_if      = 1'b0;
    s_id      = 1'b0;
    s_ex      = 1'b0;
    s_bub     = 1'b0;
    s_fif     = 1'b0;
    s_fie     = 1'b0;
    case (cur_state)
      RUN, LOAD_STALL: begin
        // LOAD_STALL behaves like RUN except that a second load-use stall is masked
        if (ex_valid && ex_branch_taken) begin
          s_fif     = 1'b1;
          s_fie     = 1'b1;
          nxt_state = FLUSH;
        end else if (ex_valid && ex_multi_start) begin
          wait_nxt  = '0;
          nxt_state = EX_WAIT;
        end else if (cur_state == RUN && load_use) begin
          s_if      = 1'b1;
          s_id      = 1'b1;
          s_bub     = 1'b1;
          nxt_state = LOAD_STALL;
        end else begin
          nxt_state = RUN;
        end
      end
      EX_WAIT: begin
        if (ex_multi_done) begin
          nxt_state = RUN;
        end else if (wait_cnt == WW'(MULTI_TIMEOUT - 1)) begin
          to_set    = 1'b1;
          nxt_state = RUN;
        end else begin
          s_if     = 1'b1;
          s_id     = 1'b1;
          s_ex     = 1'b1;
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  // Held low while reset is asserted so a live branch or load cannot leak a pulse out
  assign stall_if    = s_if  & ~reset;
  assign stall_id    = s_id  & ~reset;
  assign stall_ex    = s_ex  & ~reset;
  assign bubble_ex   = s_bub & ~reset;
  assign flush_if_id = s_fif & ~reset;
  assign flush_id_ex = s_fie & ~reset;
  assign state       = cur_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state    <= RUN;
      wait_cnt     <= '0;
      timeout_err  <= 1'b0;
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_nxt;
      if (to_set) timeout_err <= 1'b1;
      if (s_if && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (s_fif && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step queues its expected outputs, which are popped and compared at the following falling edge.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_valid;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic        ex_mem_read, ex_valid, ex_branch_taken, ex_multi_start, ex_multi_done;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, mem_valid, wb_reg_write, wb_valid;
  logic [1:0]  forward_a, forward_b, state;
  logic        stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, flush_id_ex, timeout_err;
  logic [15:0] stall_cycles, flush_count;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string       tag;
    logic [1:0]  fa, fb;
    logic [5:0]  ctl;   // stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, flush_id_ex
    logic [1:0]  st;
    logic        to;
    logic [15:0] sc, fc;
  } exp_t;

  exp_t sbq[$];

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] LDUSE = 6'b110100;
  localparam logic [5:0] WAIT  = 6'b111000;
  localparam logic [5:0] FLSH  = 6'b000011;

  pipeline_hazard_ctrl #(.MULTI_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_valid(id_valid),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .ex_valid(ex_valid), .ex_branch_taken(ex_branch_taken),
    .ex_multi_start(ex_multi_start), .ex_multi_done(ex_multi_done),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_valid(mem_valid),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_valid(wb_valid),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .state(state), .timeout_err(timeout_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired, %0d/%0d checks passed so far", passes, checks);
    $fatal(1, "watchdog");
  end

  task automatic check_out();
    exp_t e;
    logic [44:0] obs, want;
    e    = sbq.pop_front();
    obs  = {forward_a, forward_b, stall_if, stall_id, stall_ex, bubble_ex,
            flush_if_id, flush_id_ex, state, timeout_err, stall_cycles, flush_count};
    want = {e.fa, e.fb, e.ctl, e.st, e.to, e.sc, e.fc};
    checks++;
    assert (obs === want) passes++;
    else $error("FAIL %s: observed fa=%b fb=%b ctl=%b st=%0d to=%b sc=%0d fc=%0d, expected fa=%b fb=%b ctl=%b st=%0d to=%b sc=%0d fc=%0d",
                e.tag, obs[44:43], obs[42:41], obs[40:35], obs[34:33], obs[32], obs[31:16], obs[15:0],
                e.fa, e.fb, e.ctl, e.st, e.to, e.sc, e.fc);
  endtask

  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [5:0] ctl, input logic [1:0] st, input logic to,
                      input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb; e.ctl = ctl; e.st = st; e.to = to; e.sc = sc; e.fc = fc;
    sbq.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_valid = 1'b0;
    ex_rs1_addr = 5'd0; ex_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    ex_mem_read = 1'b0; ex_valid = 1'b0; ex_branch_taken = 1'b0;
    ex_multi_start = 1'b0; ex_multi_done = 1'b0;
    mem_rd_addr = 5'd0; mem_reg_write = 1'b0; mem_valid = 1'b0;
    wb_rd_addr = 5'd0; wb_reg_write = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic drive_load_use();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd7;
    id_valid = 1'b1; id_rs1_addr = 5'd2; id_rs2_addr = 5'd7;
  endtask

  initial begin
    clr_inputs();
    reset = 1'b1;
    // Live branch during reset must not produce a flush
    ex_valid = 1'b1; ex_branch_taken = 1'b1;
    step("reset_hold", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd0, 16'd0);
    reset = 1'b0;
    clr_inputs();

    // Forwarding
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd_addr = 5'd5;
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd_addr = 5'd5;
    ex_rs1_addr = 5'd5; ex_rs2_addr = 5'd9;
    step("fwd_mem_prio", 2'b10, 2'b00, NONE, 2'd0, 1'b0, 16'd0, 16'd0);
    wb_rd_addr = 5'd3; ex_rs2_addr = 5'd3;
    step("fwd_wb", 2'b10, 2'b01, NONE, 2'd0, 1'b0, 16'd0, 16'd0);
    mem_rd_addr = 5'd0; wb_rd_addr = 5'd0; ex_rs1_addr = 5'd0; ex_rs2_addr = 5'd0;
    step("fwd_x0", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd0, 16'd0);
    mem_rd_addr = 5'd3; mem_reg_write = 1'b0; wb_rd_addr = 5'd3; wb_valid = 1'b0;
    ex_rs1_addr = 5'd3; ex_rs2_addr = 5'd3;
    step("fwd_gated", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd0, 16'd0);
    clr_inputs();

    // Load-use stall, second cycle masked
    drive_load_use();
    step("load_use", 2'b00, 2'b00, LDUSE, 2'd0, 1'b0, 16'd0, 16'd0);
    step("load_stall_mask", 2'b00, 2'b00, NONE, 2'd1, 1'b0, 16'd1, 16'd0);
    clr_inputs();
    step("load_ret", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd1, 16'd0);

    // Branch beats load-use; FLUSH ignores a branch
    drive_load_use();
    ex_branch_taken = 1'b1;
    step("br_prio", 2'b00, 2'b00, FLSH, 2'd0, 1'b0, 16'd1, 16'd0);
    step("flush_state", 2'b00, 2'b00, NONE, 2'd3, 1'b0, 16'd1, 16'd1);
    clr_inputs();
    step("flush_ret", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd1, 16'd1);

    // Multi-cycle op completing on the 5th EX_WAIT cycle
    ex_valid = 1'b1; ex_multi_start = 1'b1;
    step("multi_start", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd1, 16'd1);
    ex_multi_start = 1'b0;
    for (int i = 0; i < 4; i++)
      step("multi_wait", 2'b00, 2'b00, WAIT, 2'd2, 1'b0, 16'(1 + i), 16'd1);
    ex_multi_done = 1'b1;
    step("multi_done", 2'b00, 2'b00, NONE, 2'd2, 1'b0, 16'd5, 16'd1);
    clr_inputs();
    step("multi_ret", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd5, 16'd1);

    // Branch stays live inside LOAD_STALL
    drive_load_use();
    step("ls_load", 2'b00, 2'b00, LDUSE, 2'd0, 1'b0, 16'd5, 16'd1);
    ex_branch_taken = 1'b1;
    step("ls_branch", 2'b00, 2'b00, FLSH, 2'd1, 1'b0, 16'd6, 16'd1);
    clr_inputs();
    step("ls_flush", 2'b00, 2'b00, NONE, 2'd3, 1'b0, 16'd6, 16'd2);
    step("ls_ret", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd6, 16'd2);

    // Timeout: 63 stalled EX_WAIT cycles, stall released on the 64th
    ex_valid = 1'b1; ex_multi_start = 1'b1;
    step("to_start", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd6, 16'd2);
    clr_inputs();
    for (int i = 0; i < 63; i++)
      step("to_wait", 2'b00, 2'b00, WAIT, 2'd2, 1'b0, 16'(6 + i), 16'd2);
    step("to_last", 2'b00, 2'b00, NONE, 2'd2, 1'b0, 16'd69, 16'd2);
    step("to_set", 2'b00, 2'b00, NONE, 2'd0, 1'b1, 16'd69, 16'd2);
    step("to_sticky", 2'b00, 2'b00, NONE, 2'd0, 1'b1, 16'd69, 16'd2);

    // Reset during EX_WAIT
    ex_valid = 1'b1; ex_multi_start = 1'b1;
    step("rw_start", 2'b00, 2'b00, NONE, 2'd0, 1'b1, 16'd69, 16'd2);
    ex_multi_start = 1'b0;
    step("rw_wait", 2'b00, 2'b00, WAIT, 2'd2, 1'b1, 16'd69, 16'd2);
    reset = 1'b1;
    step("rw_reset", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd0, 16'd0);
    reset = 1'b0;
    clr_inputs();
    step("rw_after", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd0, 16'd0);

    // Reset during FLUSH: first cycle after release is RUN and sees a new branch
    ex_valid = 1'b1; ex_branch_taken = 1'b1;
    step("rf_branch", 2'b00, 2'b00, FLSH, 2'd0, 1'b0, 16'd0, 16'd0);
    reset = 1'b1;
    step("rf_reset", 2'b00, 2'b00, NONE, 2'd0, 1'b0, 16'd0, 16'd0);
    reset = 1'b0;
    step("rf_run", 2'b00, 2'b00, FLSH, 2'd0, 1'b0, 16'd0, 16'd0);
    clr_inputs();
    step("rf_flush", 2'b00, 2'b00, NONE, 2'd3, 1'b0, 16'd0, 16'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
